// File: rtl/tlight_ctrl_if.sv
// Sensor inputs and light/status outputs of the traffic-light controller.
// The controller sits on the slave side; the environment drives the sensors as master.
interface tlight_ctrl_if;
    logic       ew_sensor;
    logic       emgcy_sensor;
    logic [2:0] ns_light;
    logic [2:0] ew_light;
    logic [1:0] ns_green_timer;
    logic       ew_green_req;

    modport master (
        output ew_sensor, emgcy_sensor,
        input  ns_light, ew_light, ns_green_timer, ew_green_req
    );
    modport slave (
        input  ew_sensor, emgcy_sensor,
        output ns_light, ew_light, ns_green_timer, ew_green_req
    );
endinterface

// File: rtl/tlight_ctrl.sv
// NS/EW traffic-light controller with emergency preemption and a latched EW request.
// Optional TLIGHT_EW_EXTEND_EN: EW green extends while a car waits, up to 2*EW_GREEN_CYC.
module tlight_ctrl #(
    parameter int YELLOW_CYC   = 2,
    parameter int EW_GREEN_CYC = 4,
    parameter int EMG_HOLD     = 2
) (
    input  logic         clk,
    input  logic         reset,
    tlight_ctrl_if.slave bus
);
    localparam logic [2:0] L_OFF = 3'd0, L_RED = 3'd1, L_YEL = 3'd2, L_GRN = 3'd3, L_PRE = 3'd4;
    localparam logic [3:0] YEL_LD = 4'(YELLOW_CYC - 1);
    localparam logic [3:0] EWG_LD = 4'(EW_GREEN_CYC - 1);
    localparam logic [3:0] EMG_LD = 4'(EMG_HOLD - 1);

    typedef enum logic [3:0] {
        S_OFF, S_ALL_RED, S_NS_PRE, S_NS_GREEN, S_NS_YELLOW,
        S_EW_PRE, S_EW_GREEN, S_EW_YELLOW, S_EMG_YEL, S_EMG_RED
    } state_t;

    state_t     state, state_nxt;
    logic [3:0] cnt, cnt_ld;
    logic [1:0] timer;
    logic       req, emg_ew, emg_ew_nxt;
    logic [2:0] ns_q, ew_q, ns_nxt, ew_nxt;
    logic       cnt_done, preempt, extend;

    assign cnt_done = (cnt == 4'd0);
    assign preempt  = bus.emgcy_sensor &&
                      !(state inside {S_OFF, S_EMG_YEL, S_EMG_RED});

`ifdef TLIGHT_EW_EXTEND_EN
    logic [3:0] ext;
    assign extend = bus.ew_sensor && (ext != 4'd0);

    // Remaining one-cycle extensions; caps EW green at twice its base length.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            ext <= 4'd0;
        else if (state != S_EW_GREEN)
            ext <= 4'(EW_GREEN_CYC);
        else if (cnt_done && extend && state_nxt == S_EW_GREEN)
            ext <= ext - 4'd1;
    end
`else
    assign extend = 1'b0;
`endif

    always_comb begin
        state_nxt = state;
        case (state)
            S_OFF:       state_nxt = S_ALL_RED;
            S_ALL_RED:   state_nxt = S_NS_PRE;
            S_NS_PRE:    state_nxt = S_NS_GREEN;
            S_NS_GREEN:  if (timer == 2'd3 && req) state_nxt = S_NS_YELLOW;
            S_NS_YELLOW: if (cnt_done) state_nxt = S_EW_PRE;
            S_EW_PRE:    state_nxt = S_EW_GREEN;
            S_EW_GREEN:  if (cnt_done && !extend) state_nxt = S_EW_YELLOW;
            S_EW_YELLOW: if (cnt_done) state_nxt = S_NS_PRE;
            S_EMG_YEL:   state_nxt = S_EMG_RED;
            S_EMG_RED:   if (cnt_done && !bus.emgcy_sensor) state_nxt = S_ALL_RED;
            default:     state_nxt = S_OFF;
        endcase
        // Only a currently green light needs a yellow step before red.
        if (preempt)
            state_nxt = (state == S_NS_GREEN || state == S_EW_GREEN) ? S_EMG_YEL : S_EMG_RED;
    end

    always_comb begin
        cnt_ld = 4'd0;
        case (state_nxt)
            S_NS_YELLOW, S_EW_YELLOW: cnt_ld = YEL_LD;
            S_EW_GREEN:               cnt_ld = EWG_LD;
            S_EMG_RED:                cnt_ld = EMG_LD;
            default:                  cnt_ld = 4'd0;
        endcase
    end

    assign emg_ew_nxt = (state_nxt == S_EMG_YEL) ? (state == S_EW_GREEN) : emg_ew;

    always_comb begin
        ns_nxt = L_RED;
        ew_nxt = L_RED;
        case (state_nxt)
            S_OFF:       begin ns_nxt = L_OFF; ew_nxt = L_OFF; end
            S_NS_PRE:    ns_nxt = L_PRE;
            S_NS_GREEN:  ns_nxt = L_GRN;
            S_NS_YELLOW: ns_nxt = L_YEL;
            S_EW_PRE:    ew_nxt = L_PRE;
            S_EW_GREEN:  ew_nxt = L_GRN;
            S_EW_YELLOW: ew_nxt = L_YEL;
            S_EMG_YEL:   if (emg_ew_nxt) ew_nxt = L_YEL; else ns_nxt = L_YEL;
            default:     begin ns_nxt = L_RED; ew_nxt = L_RED; end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= S_OFF;
            cnt    <= 4'd0;
            timer  <= 2'd0;
            req    <= 1'b0;
            emg_ew <= 1'b0;
            ns_q   <= L_OFF;
            ew_q   <= L_OFF;
        end else begin
            state  <= state_nxt;
            cnt    <= (state_nxt != state) ? cnt_ld : (cnt_done ? cnt : cnt - 4'd1);
            timer  <= (state == S_NS_GREEN && state_nxt == S_NS_GREEN) ?
                      ((timer == 2'd3) ? timer : timer + 2'd1) : 2'd0;
            // Request survives emergencies; only EW green service clears it.
            if (state == S_EW_PRE && state_nxt == S_EW_GREEN)
                req <= 1'b0;
            else if (bus.ew_sensor && state != S_EW_PRE && state != S_EW_GREEN)
                req <= 1'b1;
            emg_ew <= emg_ew_nxt;
            ns_q   <= ns_nxt;
            ew_q   <= ew_nxt;
        end
    end

    assign bus.ns_light       = ns_q;
    assign bus.ew_light       = ew_q;
    assign bus.ns_green_timer = timer;
    assign bus.ew_green_req   = req;
endmodule

// File: tb/tb_tlight_ctrl.sv
// Randomized bench for tlight_ctrl against a phase/age reference model.
module tb_tlight_ctrl;
    localparam int YEL = 2, EWG = 4, HOLD = 2;
`ifdef TLIGHT_EW_EXTEND_EN
    localparam bit EXT = 1'b1;
`else
    localparam bit EXT = 1'b0;
`endif
    // Phase numbering of the model
    localparam int P_OFF = 0, P_ALLR = 1, P_NSPRE = 2, P_NSG = 3, P_NSY = 4,
                   P_EWPRE = 5, P_EWG = 6, P_EWY = 7, P_EMGY = 8, P_EMGR = 9;

    logic clk = 1'b0;
    logic reset = 1'b1;
    tlight_ctrl_if bus();

    tlight_ctrl #(.YELLOW_CYC(YEL), .EW_GREEN_CYC(EWG), .EMG_HOLD(HOLD)) dut (
        .clk(clk), .reset(reset), .bus(bus)
    );

    always #5 clk = ~clk;

    int n_vec = 0, n_err = 0;
    int ph, age, m_timer;
    bit m_req, m_emg_ew;

    task automatic chk(input string tag, input int got, input int exp);
        n_vec++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s got=%0d exp=%0d t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        ph = P_OFF; age = 0; m_timer = 0; m_req = 1'b0; m_emg_ew = 1'b0;
    endtask

    task automatic model_step(input bit ew, input bit emg);
        int nph;
        nph = ph;
        if (emg && !(ph inside {P_OFF, P_EMGY, P_EMGR})) begin
            nph = (ph == P_NSG || ph == P_EWG) ? P_EMGY : P_EMGR;
            if (nph == P_EMGY) m_emg_ew = (ph == P_EWG);
        end else begin
            case (ph)
                P_OFF:   nph = P_ALLR;
                P_ALLR:  nph = P_NSPRE;
                P_NSPRE: nph = P_NSG;
                P_NSG:   if (m_timer == 3 && m_req) nph = P_NSY;
                P_NSY:   if (age + 1 >= YEL) nph = P_EWPRE;
                P_EWPRE: nph = P_EWG;
                P_EWG:   if (age + 1 >= EWG && (!(EXT && ew) || age + 1 >= 2 * EWG)) nph = P_EWY;
                P_EWY:   if (age + 1 >= YEL) nph = P_NSPRE;
                P_EMGY:  nph = P_EMGR;
                P_EMGR:  if (age + 1 >= HOLD && !emg) nph = P_ALLR;
                default: nph = P_OFF;
            endcase
        end
        if (ew && ph != P_EWPRE && ph != P_EWG) m_req = 1'b1;
        if (ph == P_EWPRE && nph == P_EWG) m_req = 1'b0;
        m_timer = (ph == P_NSG && nph == P_NSG) ? ((m_timer < 3) ? m_timer + 1 : 3) : 0;
        age = (nph == ph) ? age + 1 : 0;
        ph = nph;
    endtask

    function automatic int exp_ns();
        case (ph)
            P_OFF: return 0;
            P_NSPRE: return 4;
            P_NSG: return 3;
            P_NSY: return 2;
            P_EMGY: return m_emg_ew ? 1 : 2;
            default: return 1;
        endcase
    endfunction

    function automatic int exp_ew();
        case (ph)
            P_OFF: return 0;
            P_EWPRE: return 4;
            P_EWG: return 3;
            P_EWY: return 2;
            P_EMGY: return m_emg_ew ? 2 : 1;
            default: return 1;
        endcase
    endfunction

    task automatic compare_all();
        chk("ns_light", int'(bus.ns_light), exp_ns());
        chk("ew_light", int'(bus.ew_light), exp_ew());
        chk("ns_green_timer", int'(bus.ns_green_timer), m_timer);
        chk("ew_green_req", int'(bus.ew_green_req), int'(m_req));
    endtask

    // One clock: model advances on the edge, DUT checked on the falling edge.
    task automatic step();
        @(posedge clk);
        if (!reset) model_step(bus.ew_sensor, bus.emgcy_sensor);
        @(negedge clk);
        compare_all();
    endtask

    initial begin
        int budget;
        bus.ew_sensor = 1'b0;
        bus.emgcy_sensor = 1'b0;
        model_reset();
        repeat (2) step();
        reset = 1'b0;
        repeat (10) step();

        for (int i = 0; i < 1500; i++) begin
            bus.ew_sensor    = ($urandom_range(0, 3) == 0);
            bus.emgcy_sensor = ($urandom_range(0, 24) == 0);
            step();
        end

        // Waiting car held high across several EW green phases
        bus.emgcy_sensor = 1'b0;
        bus.ew_sensor = 1'b1;
        repeat (60) step();

        // Emergency together with a fresh request at timer saturation
        bus.ew_sensor = 1'b0;
        budget = 100;
        while (!(ph == P_NSG && m_timer == 3 && !m_req) && budget > 0) begin
            step();
            budget--;
        end
        chk("wait_nsg_sat", int'(budget > 0), 1);
        bus.ew_sensor = 1'b1;
        bus.emgcy_sensor = 1'b1;
        step();
        bus.ew_sensor = 1'b0;
        bus.emgcy_sensor = 1'b0;
        repeat (25) step();

        // Asynchronous reset in the middle of NS yellow
        bus.ew_sensor = 1'b1;
        budget = 100;
        while (ph != P_NSY && budget > 0) begin
            step();
            budget--;
        end
        chk("wait_nsy", int'(budget > 0), 1);
        reset = 1'b1;
        #1;
        model_reset();
        chk("rst_ns_light", int'(bus.ns_light), 0);
        chk("rst_ew_light", int'(bus.ew_light), 0);
        chk("rst_ew_green_req", int'(bus.ew_green_req), 0);
        bus.ew_sensor = 1'b0;
        @(negedge clk);
        step();
        reset = 1'b0;
        repeat (20) step();

        for (int i = 0; i < 500; i++) begin
            bus.ew_sensor    = ($urandom_range(0, 1) == 0);
            bus.emgcy_sensor = ($urandom_range(0, 14) == 0);
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/tlight_ctrl.md
Name: tlight_ctrl

Overview:
Traffic-light controller for a main North/South road crossed by a secondary East/West road. Drives the `ns_light` and `ew_light` outputs, which use the lights_t encoding. Reacts to the `ew_sensor` (car waiting) and `emgcy_sensor` inputs, and exports its internal `ns_green_timer` and `ew_green_req` state for property checking. This is the design block that the traffic-light assertion module binds to.

Parameters:
YELLOW_CYC, 2, cycles a light stays YELLOW on the normal path (1..15)
EW_GREEN_CYC, 4, cycles `ew_light` stays GREEN (1..15)
EMG_HOLD, 2, minimum cycles both lights stay RED after an emergency (>=2)

Ports:
clk  in  1  master clock, all state updates on posedge
reset  in  1  asynchronous, active-high reset
ew_sensor  in  1  East/West car present, sampled each posedge
emgcy_sensor  in  1  emergency request, sampled each posedge
ns_light  out  3  lights_t: OFF=0, RED=1, YELLOW=2, GREEN=3, PRE_GREEN=4
ew_light  out  3  lights_t, same encoding
ns_green_timer  out  2  cycles spent in NS_GREEN, saturating at 3
ew_green_req  out  1  latched East/West service request

Behaviour:
- Clock and reset are fixed: one clock; reset is asynchronous and active-high.
- All outputs are registered and decoded from state. An input sampled at edge t affects the outputs driven after edge t.

Reset:
- While `reset`=1: state=OFF, both lights OFF, `ns_green_timer`=0, `ew_green_req`=0, all counters 0.

State machine (`ns_light`/`ew_light`):
- OFF (OFF/OFF) -> ALL_RED on the first edge with `reset`=0.
- ALL_RED (RED/RED), 1 cycle -> NS_PRE.
- NS_PRE (PRE_GREEN/RED), 1 cycle -> NS_GREEN.
- NS_GREEN (GREEN/RED):
  - `ns_green_timer` is 0 on entry and increments each cycle, saturating at 3.
  - Exit to NS_YELLOW only when `ns_green_timer`==3 and `ew_green_req`==1.
  - Otherwise stay in NS_GREEN.
- NS_YELLOW (YELLOW/RED), YELLOW_CYC cycles -> EW_PRE.
- EW_PRE (RED/PRE_GREEN), 1 cycle -> EW_GREEN.
- EW_GREEN (RED/GREEN), EW_GREEN_CYC cycles -> EW_YELLOW.
- EW_YELLOW (RED/YELLOW), YELLOW_CYC cycles -> NS_PRE.
- EMG_YEL: for 1 cycle, any light that was GREEN shows YELLOW; every other light shows RED. Then -> EMG_RED.
- EMG_RED (RED/RED): held for at least EMG_HOLD cycles and for as long as `emgcy_sensor`=1, then -> ALL_RED.

Emergency:
- `emgcy_sensor`=1 from any state except OFF, EMG_YEL, EMG_RED forces EMG_YEL on the next edge.
- If neither light is GREEN in that state, go directly to EMG_RED instead.
- Guarantee: both lights are RED within 2 cycles of `emgcy_sensor`, and still RED 3 cycles later.

Request latch:
- `ew_green_req` sets on any sampled `ew_sensor`=1 outside EW_PRE and EW_GREEN.
- It clears on entry to EW_GREEN.
- It is not cleared by an emergency; the request is preserved.

Timer:
- `ns_green_timer` is forced to 0 in every state other than NS_GREEN.

Invariants:
- GREEN is never followed directly by RED on either light.
- The two lights are never both GREEN.
- A GREEN light is never paired with a YELLOW light on the other road.

Simultaneous events:
- Emergency has priority over every normal transition.
- `ew_sensor` arriving in the same cycle that `ns_green_timer` reaches 3 exits to NS_YELLOW on the following edge.

Reset mid-operation:
- Immediate return to OFF/OFF regardless of state.

Counters:
- 4-bit counters; they load parameter-1 on state entry and count down to 0.

Optional Feature:
TLIGHT_EW_EXTEND_EN
- Defined: in EW_GREEN, when the cycle counter expires while `ew_sensor`=1, GREEN is extended one cycle at a time. Extension stops at a total of 2*EW_GREEN_CYC cycles. Emergency still preempts.
- Undefined: EW_GREEN lasts exactly EW_GREEN_CYC cycles.

Test Plan:
1. Reset, then deassert reset; hold `ew_sensor`=0 -> OFF/OFF, then RED/RED 1 cycle, then PRE_GREEN/RED 1 cycle, then GREEN/RED indefinitely; `ns_green_timer` goes 0,1,2,3,3.
2. `ew_sensor` pulsed 1 cycle while `ns_green_timer`=1 -> `ew_green_req`=1; NS YELLOW 2 cycles after the timer hits 3; then RED/PRE_GREEN; then RED/GREEN for 4 cycles; `ew_green_req` clears on GREEN entry.
3. `emgcy_sensor` pulsed during EW_GREEN -> next cycle RED/YELLOW, then RED/RED for 2 cycles, then ALL_RED, then NS_PRE, then NS_GREEN; `ew_light` never goes GREEN to RED.
4. `emgcy_sensor` asserted together with `ew_sensor` at `ns_green_timer`==3 -> emergency wins (YELLOW/RED, then RED/RED); `ew_green_req` stays 1 and is served after recovery.
5. Assert `reset` asynchronously mid-NS_YELLOW -> outputs OFF/OFF before the next clock edge; `ew_green_req`=0.
6. With TLIGHT_EW_EXTEND_EN and `ew_sensor` held high -> EW GREEN lasts 8 cycles, then YELLOW; without the macro it lasts 4 cycles.
